mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one memory bus between the core's instruction-fetch port and data port.
//  Sequences each access as request -> bus grant -> bus ack -> one-cycle response.
//  Gives data priority, with bounded fetch starvation and a bus timeout.
//  Sits between the core's IMEM/DMEM ports and the system memory/bus; busy_o feeds the core's halt input.
// PARAMETERS
//  ADDR_WIDTH      32   address width of all ports
//  DATA_WIDTH      32   data width of all ports
//  STARVE_LIMIT    4    consecutive D grants allowed while I is pending (>=1)
//  TIMEOUT_CYCLES  255  max cycles waiting for m_ack_i; 0 disables timeout
// PORTS
//  clk_i      in   1           clock; all state changes on its rising edge
//  rst_i      in   1           reset, asynchronous, active-low
//  i_req_i    in   1           fetch request; held until i_ack_o
//  i_addr_i   in   ADDR_WIDTH  fetch address
//  i_ack_o    out  1           fetch response strobe, one cycle
//  i_data_o   out  DATA_WIDTH  fetched word; valid with i_ack_o
//  d_req_i    in   1           data request; held until d_ack_o
//  d_we_i     in   1           1 = store, 0 = load
//  d_addr_i   in   ADDR_WIDTH  data address
//  d_data_i   in   DATA_WIDTH  store data
//  d_width_i  in   3           access width code (funct3 encoding)
//  d_ack_o    out  1           data response strobe, one cycle
//  d_data_o   out  DATA_WIDTH  load data; valid with d_ack_o
//  err_o      out  1           with i_ack_o/d_ack_o: access timed out
//  m_req_o    out  1           bus request; held until m_ack_i or timeout
//  m_we_o     out  1           bus write enable
//  m_addr_o   out  ADDR_WIDTH  bus address
//  m_data_o   out  DATA_WIDTH  bus write data
//  m_width_o  out  3           bus access width; 3'b010 for fetches
//  m_ack_i    in   1           bus completion; m_data_i valid in the same cycle
//  m_data_i   in   DATA_WIDTH  bus read data
//  busy_o     out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst_i low, async): state IDLE, all outputs 0, starve_cnt=0, tmo_cnt=0.
//    Reset mid-access drops m_req_o immediately; no ack is issued.
//  FSM: IDLE, GNT_I, GNT_D, RESP.
//  IDLE
//    d_req_i & (~i_req_i | starve_cnt<STARVE_LIMIT) -> GNT_D.
//    else i_req_i -> GNT_I.
//    On the transition, latch addr/data/we/width into m_* regs and set m_req_o=1.
//      Output is registered: m_req_o rises the cycle after the request is sampled.
//  starve_cnt
//    +1 on each D grant made while i_req_i=1 (saturating); cleared on each I grant.
//    Both requests pending with starve_cnt==STARVE_LIMIT -> I granted.
//  GNT_x
//    m_* held stable while m_req_o=1.
//    tmo_cnt increments each cycle.
//    m_ack_i=1: capture m_data_i in rdata, err=0, m_req_o=0, -> RESP.
//    tmo_cnt==TIMEOUT_CYCLES-1 without ack (TIMEOUT_CYCLES!=0):
//      rdata=0, err=1, m_req_o=0, -> RESP.
//    Ack and timeout in the same cycle: ack wins, err=0.
//  RESP
//    Exactly one cycle.
//    Granted side's x_ack_o=1 with x_data_o=rdata; err_o=err.
//    All requests ignored; -> IDLE.
//    Requester must drop or replace req by the next edge.
//    Minimum access: 1 cycle to grant + bus latency + 1 RESP cycle.
//  Read data is captured for stores too (value don't-care; err_o still valid).
//  x_data_o holds the last rdata between acks.
//  m_we_o=0 for fetches.
//  tmo_cnt width: $clog2(TIMEOUT_CYCLES+1); cleared on entry to GNT_x.
// STRUCTURE
//  Shared defines header: state encodings, __MEM_W_WORD__ (3'b010), width codes.
//    The core's Decode uses the same width codes.
//  One sub-module: bus_timer (load/clear, enable, terminal-count pulse;
//    parameter LIMIT) implements tmo_cnt.
//  Everything else stays in mem_arbiter.
// TESTING
//  1. Fetch only: i_req_i=1 at addr 0x100, m_ack_i 2 cycles after m_req_o
//     with 0xDEADBEEF -> i_data_o=0xDEADBEEF, i_ack_o single pulse,
//     m_width_o=3'b010, m_we_o=0.
//  2. Both requests in the same cycle with STARVE_LIMIT=4 -> D granted first,
//     then I; D with d_we_i=1 drives m_data_o=d_data_i and m_we_o=1.
//  3. Starvation: d_req_i and i_req_i held high, bus acks in 1 cycle
//     -> grant order D,D,D,D,I,D,...; never 5 consecutive D grants.
//  4. Timeout: TIMEOUT_CYCLES=8, m_ack_i never asserted -> m_req_o high
//     exactly 8 cycles, then d_ack_o=1, err_o=1, d_data_o=0.
//  5. m_ack_i in the last timeout cycle -> err_o=0, data returned.
//  6. Reset mid-GNT_D: rst_i low -> m_req_o and busy_o fall asynchronously,
//     no ack; after release an i_req_i is served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the memory arbiter.
//   state_t     - arbiter FSM states
//   mem_width_t - access width codes (funct3 encoding, shared with Decode)
//   cnt_width() - counter width able to hold 0..limit (never zero bits)
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GNT_I,
        ST_GNT_D,
        ST_RESP
    } state_t;

    typedef enum logic [2:0] {
        MEM_W_BYTE  = 3'b000,
        MEM_W_HALF  = 3'b001,
        MEM_W_WORD  = 3'b010,
        MEM_W_BYTEU = 3'b100,
        MEM_W_HALFU = 3'b101
    } mem_width_t;

    function automatic int cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_bus_timer.sv
// mem_arbiter_bus_timer: bus-ack timeout counter.
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   clear  in  force count to zero (held while the arbiter is idle)
//   en     in  count one cycle of waiting on the bus
//   tc     out terminal count: this enabled cycle is cycle LIMIT of the wait
// LIMIT = 0 disables the timeout; tc then never asserts.
module mem_arbiter_bus_timer
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CW = cnt_width(LIMIT);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (LIMIT != 0) && en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch (I) and data (D).
// Each access runs IDLE -> GNT_x (bus request held until ack/timeout) -> RESP
// (one-cycle response strobe) -> IDLE. D has priority, but after STARVE_LIMIT
// consecutive D grants with I waiting, I is granted.
//   clk_i, rst_i            clock, asynchronous active-low reset
//   i_req_i/i_addr_i        fetch request        -> i_ack_o/i_data_o
//   d_req_i/d_we_i/d_addr_i/d_data_i/d_width_i
//                           data request         -> d_ack_o/d_data_o
//   err_o                   with an ack: the access timed out
//   m_req_o/m_we_o/m_addr_o/m_data_o/m_width_o   bus request side
//   m_ack_i/m_data_i        bus completion and read data
//   busy_o                  high whenever the arbiter is not idle
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_req_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    output logic                  i_ack_o,
    output logic [DATA_WIDTH-1:0] i_data_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_data_i,
    input  logic [2:0]            d_width_i,
    output logic                  d_ack_o,
    output logic [DATA_WIDTH-1:0] d_data_o,
    output logic                  err_o,
    output logic                  m_req_o,
    output logic                  m_we_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [2:0]            m_width_o,
    input  logic                  m_ack_i,
    input  logic [DATA_WIDTH-1:0] m_data_i,
    output logic                  busy_o
);

    localparam int SW = cnt_width(STARVE_LIMIT);

    state_t                state;
    logic [SW-1:0]         starve_cnt;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  in_gnt;
    logic                  grant_d;
    logic                  tmo_hit;

    assign in_gnt  = (state == ST_GNT_I) || (state == ST_GNT_D);
    // D wins unless I is waiting and D has already used up its streak.
    assign grant_d = d_req_i && (!i_req_i || (starve_cnt < SW'(STARVE_LIMIT)));

    // Held clear while idle, so every grant starts its wait from zero.
    mem_arbiter_bus_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk_i),
        .rst_n (rst_i),
        .clear (state == ST_IDLE),
        .en    (in_gnt),
        .tc    (tmo_hit)
    );

    // Both response ports show the last captured word between acks.
    assign i_data_o = rdata;
    assign d_data_o = rdata;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: datapath registers are reset as well, so every output
            // reads zero while reset is asserted.
            state      <= ST_IDLE;
            starve_cnt <= '0;
            rdata      <= '0;
            i_ack_o    <= 1'b0;
            d_ack_o    <= 1'b0;
            err_o      <= 1'b0;
            m_req_o    <= 1'b0;
            m_we_o     <= 1'b0;
            m_addr_o   <= '0;
            m_data_o   <= '0;
            m_width_o  <= '0;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        state     <= ST_GNT_D;
                        m_req_o   <= 1'b1;
                        m_we_o    <= d_we_i;
                        m_addr_o  <= d_addr_i;
                        m_data_o  <= d_data_i;
                        m_width_o <= d_width_i;
                        busy_o    <= 1'b1;
                        // Only grants that bypass a waiting fetch count.
                        if (i_req_i && (starve_cnt < SW'(STARVE_LIMIT))) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end else if (i_req_i) begin
                        state      <= ST_GNT_I;
                        m_req_o    <= 1'b1;
                        m_we_o     <= 1'b0;
                        m_addr_o   <= i_addr_i;
                        m_data_o   <= '0;
                        m_width_o  <= MEM_W_WORD;
                        busy_o     <= 1'b1;
                        starve_cnt <= '0;
                    end
                end

                ST_GNT_I, ST_GNT_D: begin
                    // Ack is tested first so a late ack still beats the timeout.
                    if (m_ack_i || tmo_hit) begin
                        state   <= ST_RESP;
                        m_req_o <= 1'b0;
                        rdata   <= m_ack_i ? m_data_i : '0;
                        err_o   <= !m_ack_i;
                        i_ack_o <= (state == ST_GNT_I);
                        d_ack_o <= (state == ST_GNT_D);
                    end
                end

                ST_RESP: begin
                    // Requests are ignored here; the requester updates req now.
                    state   <= ST_IDLE;
                    i_ack_o <= 1'b0;
                    d_ack_o <= 1'b0;
                    err_o   <= 1'b0;
                    busy_o  <= 1'b0;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
// A transaction-level model predicts grants, bus fields, response data and
// timing; literal checks pin the model on the hand-computed scenarios.
module tb_mem_arbiter;

    localparam int STARVE = 4;
    localparam int TMO    = 8;
    localparam logic [31:0] BAD = 32'hBAD0_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        i_req_i = 1'b0;
    logic [31:0] i_addr_i = '0;
    logic        i_ack_o;
    logic [31:0] i_data_o;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [31:0] d_addr_i = '0;
    logic [31:0] d_data_i = '0;
    logic [2:0]  d_width_i = '0;
    logic        d_ack_o;
    logic [31:0] d_data_o;
    logic        err_o;
    logic        m_req_o;
    logic        m_we_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_o;
    logic [2:0]  m_width_o;
    logic        m_ack_i = 1'b0;
    logic [31:0] m_data_i = '0;
    logic        busy_o;

    mem_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .STARVE_LIMIT   (STARVE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_req_i   (i_req_i),
        .i_addr_i  (i_addr_i),
        .i_ack_o   (i_ack_o),
        .i_data_o  (i_data_o),
        .d_req_i   (d_req_i),
        .d_we_i    (d_we_i),
        .d_addr_i  (d_addr_i),
        .d_data_i  (d_data_i),
        .d_width_i (d_width_i),
        .d_ack_o   (d_ack_o),
        .d_data_o  (d_data_o),
        .err_o     (err_o),
        .m_req_o   (m_req_o),
        .m_we_o    (m_we_o),
        .m_addr_o  (m_addr_o),
        .m_data_o  (m_data_o),
        .m_width_o (m_width_o),
        .m_ack_i   (m_ack_i),
        .m_data_i  (m_data_i),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %s want %s", name, act, exp);
        end
    endtask

    // Run control (written by the main sequence only).
    int          cfg_ni = 0, cfg_nd = 0, ack_lat = 0, go_req = 0;
    logic [31:0] rd_base = 32'h0;
    bit          rd_vary = 1'b0;

    // Requester / bus-responder state (written by the drive process only).
    int go_seen = 0, i_left = 0, d_left = 0, i_idx = 0, d_idx = 0, hc = 0, cyc = 0;

    // Monitor state (written by the negedge process only).
    bit          i_ack_q = 1'b0, d_ack_q = 1'b0, mreq_prev = 1'b0;
    string       order = "";
    int          run = 0, last_run = 0, n_i_ack = 0, n_d_ack = 0;
    logic [31:0] last_i_data = '0, last_d_data = '0, i_addr_seen = '0, d_dat_seen = '0;
    logic        last_err = 1'b0, i_we_seen = 1'b0, d_we_seen = 1'b0;
    logic [2:0]  i_width_seen = '0;

    task automatic drive_d(input int k);
        d_we_i    = (k % 2 == 0);
        d_addr_i  = 32'h2000 + 32'(k) * 4;
        d_data_i  = 32'h5A00_0000 + 32'(k);
        d_width_i = 3'(k % 3);
    endtask

    // Requesters and bus responder, driven 1 time unit after each rising edge.
    initial forever begin
        @(posedge clk_i);
        #1;
        cyc++;
        if (!rst_i || !m_req_o) begin
            hc = 0; m_ack_i = 1'b0; m_data_i = BAD;
        end else begin
            hc++;
            if (ack_lat >= 0 && hc == ack_lat + 1) begin
                m_ack_i  = 1'b1;
                m_data_i = rd_vary ? rd_base + 32'(cyc) : rd_base;
            end else begin
                m_ack_i = 1'b0; m_data_i = BAD;
            end
        end
        if (!rst_i) begin
            i_req_i = 1'b0; d_req_i = 1'b0; i_left = 0; d_left = 0; go_seen = go_req;
        end else if (go_req != go_seen) begin
            go_seen = go_req; i_left = cfg_ni; d_left = cfg_nd; i_idx = 0; d_idx = 0;
            if (i_left > 0) begin i_addr_i = 32'h100; i_req_i = 1'b1; end
            if (d_left > 0) begin drive_d(0); d_req_i = 1'b1; end
        end else begin
            // An ack seen last cycle: replace the request or drop it.
            if (i_ack_q && i_left > 0) begin
                i_left--; i_idx++;
                if (i_left > 0) i_addr_i = 32'h100 + 32'(i_idx) * 4;
                else i_req_i = 1'b0;
            end
            if (d_ack_q && d_left > 0) begin
                d_left--; d_idx++;
                if (d_left > 0) drive_d(d_idx);
                else d_req_i = 1'b0;
            end
        end
    end

    // Monitor plus transaction-level model; compares on every falling edge.
    typedef enum {M_IDLE, M_BUS, M_RESP} mphase_t;
    mphase_t     ph = M_IDLE;
    int          s = 0, g_cyc = 0;
    bit          g_d = 1'b0, g_we = 1'b0, r_err = 1'b0;
    logic [31:0] g_addr = '0, g_data = '0, r_data = '0;
    logic [2:0]  g_width = '0;

    initial forever begin
        @(negedge clk_i);
        i_ack_q = i_ack_o;
        d_ack_q = d_ack_o;
        if (rst_i) begin
            if (m_req_o && !mreq_prev) begin
                if (m_addr_o[13]) begin
                    order = {order, "D"}; d_we_seen = m_we_o; d_dat_seen = m_data_o;
                end else begin
                    order = {order, "I"}; i_we_seen = m_we_o; i_width_seen = m_width_o;
                    i_addr_seen = m_addr_o;
                end
            end
            if (m_req_o) run++;
            else if (run > 0) begin last_run = run; run = 0; end
            if (i_ack_o) begin n_i_ack++; last_i_data = i_data_o; last_err = err_o; end
            if (d_ack_o) begin n_d_ack++; last_d_data = d_data_o; last_err = err_o; end
        end else begin
            run = 0;
        end
        mreq_prev = m_req_o;

        if (!rst_i) begin
            check("rst i_ack", i_ack_o, 0);
            check("rst d_ack", d_ack_o, 0);
            check("rst m_req", m_req_o, 0);
            check("rst busy", busy_o, 0);
            check("rst err", err_o, 0);
            check("rst m_we", m_we_o, 0);
            check("rst m_addr", m_addr_o, 0);
            check("rst m_data", m_data_o, 0);
            check("rst m_width", m_width_o, 0);
            check("rst i_data", i_data_o, 0);
            check("rst d_data", d_data_o, 0);
            ph = M_IDLE; s = 0;
        end else begin
            case (ph)
                M_IDLE: begin
                    check("idle m_req", m_req_o, 0);
                    check("idle busy", busy_o, 0);
                    check("idle acks", {i_ack_o, d_ack_o}, 0);
                    if (d_req_i && (!i_req_i || s < STARVE)) begin
                        g_d = 1'b1; g_addr = d_addr_i; g_we = d_we_i;
                        g_data = d_data_i; g_width = d_width_i;
                        if (i_req_i && s < STARVE) s++;
                        ph = M_BUS; g_cyc = 0;
                    end else if (i_req_i) begin
                        g_d = 1'b0; g_addr = i_addr_i; g_we = 1'b0; g_width = 3'b010;
                        s = 0; ph = M_BUS; g_cyc = 0;
                    end
                end
                M_BUS: begin
                    check("bus m_req", m_req_o, 1);
                    check("bus busy", busy_o, 1);
                    check("bus acks", {i_ack_o, d_ack_o}, 0);
                    check("bus m_addr", m_addr_o, g_addr);
                    check("bus m_we", m_we_o, g_we);
                    check("bus m_width", m_width_o, g_width);
                    if (g_d) check("bus m_data", m_data_o, g_data);
                    g_cyc++;
                    if (m_ack_i) begin
                        r_data = m_data_i; r_err = 1'b0; ph = M_RESP;
                    end else if (g_cyc == TMO) begin
                        r_data = '0; r_err = 1'b1; ph = M_RESP;
                    end
                end
                M_RESP: begin
                    check("resp i_ack", i_ack_o, !g_d);
                    check("resp d_ack", d_ack_o, g_d);
                    check("resp data", g_d ? d_data_o : i_data_o, r_data);
                    check("resp err", err_o, r_err);
                    check("resp m_req", m_req_o, 0);
                    check("resp busy", busy_o, 1);
                    ph = M_IDLE;
                end
                default: ph = M_IDLE;
            endcase
        end
    end

    task automatic wait_done(input string name);
        int c = 0;
        while ((go_seen != go_req || i_left > 0 || d_left > 0) && c < 2000) begin
            @(posedge clk_i);
            c++;
        end
        check({name, " completes"}, (c < 2000), 1);
        repeat (3) @(posedge clk_i);
    endtask

    task automatic run_seq(input int ni, input int nd, input int lat, input string name);
        ack_lat = lat; cfg_ni = ni; cfg_nd = nd;
        go_req++;
        wait_done(name);
    endtask

    initial begin
        int    mark, ni0, nd0, c;
        string got;

        // Reset state.
        #3;
        check("reset m_req", m_req_o, 0);
        check("reset busy", busy_o, 0);
        check("reset acks", {i_ack_o, d_ack_o, err_o}, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);

        // 1: fetch only, ack two cycles after m_req_o rises.
        rd_base = 32'hDEAD_BEEF; rd_vary = 1'b0; ni0 = n_i_ack;
        run_seq(1, 0, 2, "fetch");
        check("t1 i_data", last_i_data, 32'hDEAD_BEEF);
        check("t1 ack count", n_i_ack - ni0, 1);
        check("t1 m_req cycles", last_run, 3);
        check("t1 m_width", i_width_seen, 3'b010);
        check("t1 m_we", i_we_seen, 0);
        check("t1 m_addr", i_addr_seen, 32'h100);
        check("t1 err", last_err, 0);

        // 2: simultaneous requests, D (a store) first.
        rd_vary = 1'b1; mark = order.len();
        run_seq(1, 1, 1, "both");
        got = order.substr(mark, order.len() - 1);
        check_str("t2 order", got, "DI");
        check("t2 d m_we", d_we_seen, 1);
        check("t2 d m_data", d_dat_seen, 32'h5A00_0000);

        // 3: starvation bound with single-cycle bus.
        mark = order.len();
        run_seq(3, 10, 0, "starve");
        got = order.substr(mark, order.len() - 1);
        check_str("t3 order", got, "DDDDIDDDDIDDI");

        // Mixed traffic, different bus latencies.
        run_seq(3, 3, 1, "mix1");
        run_seq(2, 4, 3, "mix2");

        // 4: timeout, bus never acks.
        nd0 = n_d_ack;
        run_seq(0, 1, -1, "timeout");
        check("t4 m_req cycles", last_run, 8);
        check("t4 d_ack count", n_d_ack - nd0, 1);
        check("t4 d_data", last_d_data, 32'h0);
        check("t4 err", last_err, 1);

        // 5: ack in the last timeout cycle wins.
        rd_base = 32'h1234_5678; rd_vary = 1'b0;
        run_seq(1, 0, 7, "late ack");
        check("t5 m_req cycles", last_run, 8);
        check("t5 i_data", last_i_data, 32'h1234_5678);
        check("t5 err", last_err, 0);

        // 6: reset in the middle of a data grant.
        ack_lat = -1; cfg_ni = 0; cfg_nd = 1; go_req++;
        c = 0;
        while (!m_req_o && c < 50) begin @(negedge clk_i); c++; end
        check("t6 grant seen", m_req_o, 1);
        repeat (3) @(negedge clk_i);
        nd0 = n_d_ack;
        #2 rst_i = 1'b0;
        #1;
        check("t6 m_req async", m_req_o, 0);
        check("t6 busy async", busy_o, 0);
        repeat (4) @(posedge clk_i);
        #1 rst_i = 1'b1;
        check("t6 no ack", n_d_ack - nd0, 0);
        repeat (2) @(posedge clk_i);
        rd_base = 32'hCAFE_F00D; ni0 = n_i_ack;
        run_seq(1, 0, 1, "after reset");
        check("t6 i_data", last_i_data, 32'hCAFE_F00D);
        check("t6 ack count", n_i_ack - ni0, 1);
        check("t6 err", last_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
